osc_freq_meter: RTL and testbench
=================================

// Module: osc_freq_meter
// PURPOSE
//  Multi-channel ring-oscillator frequency meter. One of NUM_OSC free-running oscillator
//  nets is selected, divided by a programmable ripple prescaler and synchronised into clk.
//  Prescaled rising edges are counted over a gate window of 2^gate_sel clk cycles.
//  Sits between the on-die ring oscillators and the tile's output/readout logic.
//  The selected prescaled clock is also exported for direct probing on a pin.
// PARAMETERS
//  NUM_OSC       4   number of oscillator inputs; SEL_W = $clog2(NUM_OSC), min 1
//  PRESCALE_LOG2 3   oscillator-domain ripple divide ratio = 2^PRESCALE_LOG2 (1..8)
//  CNT_W         16  edge-count result width
//  GATE_W        4   gate_sel width; gate length G = 2^gate_sel clk cycles
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        synchronous active-low reset
//  osc_in       in   NUM_OSC  raw oscillator nets, asynchronous to clk
//  osc_sel      in   SEL_W    channel select, latched on accepted start
//  gate_sel     in   GATE_W   gate exponent, latched on accepted start
//  start        in   1        request one measurement; honoured only in IDLE
//  busy         out  1        high from cycle after accepted start until count_valid
//  count        out  CNT_W    last result; holds until next DONE
//  overflow     out  1        last result saturated
//  count_valid  out  1        one-cycle pulse when count/overflow update
//  osc_div_out  out  1        prescaler MSB of the selected channel
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state IDLE; busy=0, count=0, overflow=0,
//    count_valid=0; edge counter and synchroniser flops=0. Reset mid-measurement
//    aborts it: no count_valid, result cleared.
//  - Prescaler: ripple toggle chain clocked by osc_in[sel_q]. sel_q is the latched
//    select, so osc_in muxing changes only on accepted start. The chain clears while
//    rst_n=0, sampled on its own oscillator edges; it is free-running otherwise.
//  - Sync: 3-flop chain on the prescaler MSB in clk. Edge = s[1] & ~s[2].
//    Correct only while f_osc / 2^PRESCALE_LOG2 < f_clk/2 (integrator constraint).
//  - FSM: IDLE -> SETTLE -> GATE -> DONE -> IDLE.
//    IDLE: when start=1, latch osc_sel/gate_sel, clear edge counter, go SETTLE.
//      An osc_sel >= NUM_OSC selects channel 0.
//    SETTLE: exactly 4 cycles, edges ignored; flushes mux-switch glitches and the sync.
//    GATE: exactly G = 2^gate_sel cycles; each detected edge increments the counter.
//      The counter saturates at 2^CNT_W-1 and sets a sticky overflow flag for this run.
//    DONE: 1 cycle. count <= counter, overflow <= flag, count_valid=1 next edge.
//      busy drops in the same cycle count_valid rises.
//  - Latency: start accepted at edge N -> count_valid high in cycle N+4+G+2.
//  - start while busy: ignored, not queued. start held high in IDLE: back-to-back runs.
//  - Result: f_osc ~= count * 2^PRESCALE_LOG2 * f_clk / G, +/-1 count quantisation.
// CONFIGURATION
//  OSC_METER_CONTINUOUS_EN defined: DONE returns to SETTLE, not IDLE, using the same
//    latched osc_sel/gate_sel. The meter re-measures forever, with count_valid every
//    G+5 cycles and busy held 1. Only reset stops it; start is ignored after the first run.
//  Not defined: single-shot only, exactly as in BEHAVIOUR.
// TESTING
//  1 Reset: rst_n=0 for 3 clk -> busy=0, count=0, overflow=0, count_valid=0.
//  2 Basic: clk 100MHz, osc_in[0] 40MHz, gate_sel=10, start pulse -> valid after 1030
//    cycles; count in 51..52; overflow=0; osc_div_out period 200ns.
//  3 Channel: osc_in[2]=20MHz, osc_sel=2, gate_sel=10 -> count in 25..26.
//    Repeat osc_sel=3 with osc_in[3] tied 0 -> count=0.
//  4 Overflow: CNT_W=8, osc 200MHz (prescaled 25MHz), gate_sel=12 -> count=255, overflow=1.
//    A following run with gate_sel=4 -> overflow=0.
//  5 Handshake: start pulsed during GATE -> ignored, exactly one count_valid.
//    rst_n=0 mid-GATE -> no count_valid, count=0, busy=0 next cycle.
//  6 OSC_METER_CONTINUOUS_EN: gate_sel=6, one start -> count_valid every 69 cycles
//    for 10 pulses, busy stays 1, all counts within +/-1 of each other.

Source files
------------

// File: rtl/osc_freq_meter.sv
// Ring-oscillator frequency meter: select, prescale, synchronise and gate-count one oscillator.
// Optional build macro OSC_METER_CONTINUOUS_EN makes the meter re-measure forever after one start.
module osc_freq_meter #(
    parameter int NUM_OSC       = 4,
    parameter int PRESCALE_LOG2 = 3,
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 4,
    localparam int SEL_W        = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_OSC-1:0] osc_in,
    input  logic [SEL_W-1:0]   osc_sel,
    input  logic [GATE_W-1:0]  gate_sel,
    input  logic               start,
    output logic               busy,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic               count_valid,
    output logic               osc_div_out
);

    localparam int TMR_W = 2 ** GATE_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [SEL_W-1:0]         sel_q;
    logic [GATE_W-1:0]        gate_q;
    logic [SEL_W-1:0]         sel_valid;
    logic                     osc_clk;
    logic [PRESCALE_LOG2-1:0] div;
    logic [2:0]               sync;
    logic                     osc_edge;
    logic                     accept;
    logic [1:0]               settle_cnt;
    logic [TMR_W-1:0]         gate_tmr;
    logic [CNT_W-1:0]         edge_cnt;
    logic                     ovf_flag;

    // Out-of-range selects fall back to channel 0.
    assign sel_valid = (32'(osc_sel) < NUM_OSC) ? osc_sel : '0;
    assign accept    = (state == IDLE) && start;

    // Oscillator domain: sel_q only moves on an accepted start, so the mux is static while counting.
    assign osc_clk = osc_in[sel_q];

    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            div <= '0;
        end else begin
            div <= div + PRESCALE_LOG2'(1);
        end
    end

    assign osc_div_out = div[PRESCALE_LOG2-1];

    // Clock domain crossing into clk; edge taken between the 2nd and 3rd flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], osc_div_out};
        end
    end

    assign osc_edge = sync[1] & ~sync[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = SETTLE;
            SETTLE: if (settle_cnt == 2'd0) state_next = GATE;
            GATE:   if (gate_tmr == '0) state_next = DONE;
`ifdef OSC_METER_CONTINUOUS_EN
            DONE:   state_next = SETTLE;
`else
            DONE:   state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q  <= '0;
            gate_q <= '0;
        end else if (accept) begin
            sel_q  <= sel_valid;
            gate_q <= gate_sel;
        end
    end

    // SETTLE runs while settle_cnt counts 3..0; gate_tmr is reloaded with G-1 until GATE begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= 2'd3;
            gate_tmr   <= '0;
        end else begin
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 2'd1;
                gate_tmr   <= (TMR_W'(1) << gate_q) - TMR_W'(1);
            end else begin
                settle_cnt <= 2'd3;
                if (state == GATE) begin
                    gate_tmr <= gate_tmr - TMR_W'(1);
                end
            end
        end
    end

    // Edge counter saturates at all-ones; the overflow flag is sticky for the current run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else if (accept || (state == DONE)) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else if ((state == GATE) && osc_edge) begin
            if (edge_cnt == '1) begin
                ovf_flag <= 1'b1;
            end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= (state == DONE);
            if (state == DONE) begin
                count    <= edge_cnt;
                overflow <= ovf_flag;
            end
        end
    end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter: table of single-shot runs plus handshake/reset sequences.
`timescale 1ns/100ps
module tb_osc_freq_meter;

    localparam int NUM_OSC = 4;
    localparam int PL      = 3;
    localparam int CNT_W   = 8;
    localparam int GATE_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             o0 = 1'b0;
    logic             o1 = 1'b0;
    logic             o2 = 1'b0;
    logic [3:0]       osc_in;
    logic [1:0]       osc_sel = '0;
    logic [3:0]       gate_sel = '0;
    logic             start = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             count_valid;
    logic             osc_div_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        int sel;
        int gate;
        int lo;
        int hi;
        int ovf;
    } vec_t;

    vec_t vecs[7];

    assign osc_in = {1'b0, o2, o1, o0};

    always #5 clk = ~clk;
    initial begin #1.3; forever #12.5 o0 = ~o0; end
    initial begin #1.7; forever #2.5 o1 = ~o1; end
    initial begin #2.1; forever #25 o2 = ~o2; end

    osc_freq_meter #(
        .NUM_OSC(NUM_OSC), .PRESCALE_LOG2(PL), .CNT_W(CNT_W), .GATE_W(GATE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .osc_sel(osc_sel),
        .gate_sel(gate_sel), .start(start), .busy(busy), .count(count),
        .overflow(overflow), .count_valid(count_valid), .osc_div_out(osc_div_out)
    );

    task automatic check(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for count_valid; cyc counts the accept edge as 1.
    task automatic run_meas(input int sel, input int gate, output int cyc, output int cnt,
                            output int ovf, output int busy_early, output int busy_end,
                            output int valid_after);
        @(negedge clk);
        osc_sel  = 2'(sel);
        gate_sel = 4'(gate);
        start    = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1 start = 1'b0;
        @(negedge clk);
        busy_early = int'(busy);
        while (!count_valid && cyc < 40000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        cnt      = int'(count);
        ovf      = int'(overflow);
        busy_end = int'(busy);
        @(negedge clk);
        valid_after = int'(count_valid);
    endtask

    task automatic wait_div_rise(output realtime t, output int ok);
        logic prev;
        ok   = 0;
        t    = 0.0;
        prev = osc_div_out;
        for (int s = 0; s < 5000; s++) begin
            #0.1;
            if (!prev && osc_div_out) begin
                t  = $realtime;
                ok = 1;
                break;
            end
            prev = osc_div_out;
        end
    endtask

    task automatic count_pulses(input int ncyc, output int n);
        n = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (count_valid) n++;
        end
    endtask

    initial begin
        int cyc, cnt, ovf, be, bend, va, npulse, ok1, ok2;
        realtime t1, t2;

        vecs[0] = '{0, 10, 51, 52, 0};
        vecs[1] = '{2, 10, 25, 26, 0};
        vecs[2] = '{3, 10, 0, 0, 0};
        vecs[3] = '{1, 12, 255, 255, 1};
        vecs[4] = '{1, 4, 3, 5, 0};
        vecs[5] = '{0, 6, 3, 4, 0};
        vecs[6] = '{2, 0, 0, 1, 0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0, 0);
        check("reset_count", int'(count), 0, 0);
        check("reset_overflow", int'(overflow), 0, 0);
        check("reset_valid", int'(count_valid), 0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifndef OSC_METER_CONTINUOUS_EN
        for (int i = 0; i < 7; i++) begin
            run_meas(vecs[i].sel, vecs[i].gate, cyc, cnt, ovf, be, bend, va);
            check($sformatf("v%0d_latency", i), cyc, (1 << vecs[i].gate) + 6, (1 << vecs[i].gate) + 6);
            check($sformatf("v%0d_count", i), cnt, vecs[i].lo, vecs[i].hi);
            check($sformatf("v%0d_overflow", i), ovf, vecs[i].ovf, vecs[i].ovf);
            check($sformatf("v%0d_busy_early", i), be, 1, 1);
            check($sformatf("v%0d_busy_at_valid", i), bend, 0, 0);
            check($sformatf("v%0d_valid_pulse", i), va, 0, 0);
            if (i == 0) begin
                wait_div_rise(t1, ok1);
                wait_div_rise(t2, ok2);
                check("div_period_x10", (ok1 && ok2) ? int'((t2 - t1) * 10.0) : -1, 1995, 2005);
            end
        end

        // start pulsed during GATE must be ignored.
        @(negedge clk);
        osc_sel = 2'd0;
        gate_sel = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        npulse = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (k == 20) start = 1'b1;
            if (k == 21) start = 1'b0;
            if (count_valid) begin
                npulse++;
                check("gate_start_count", int'(count), 3, 4);
            end
        end
        check("gate_start_pulses", npulse, 1, 1);

        // start held high: back-to-back runs every G+6 edges.
        @(negedge clk);
        gate_sel = 4'd2;
        start = 1'b1;
        @(posedge clk);
        count_pulses(45, npulse);
        start = 1'b0;
        check("b2b_pulses", npulse, 4, 4);
        count_pulses(20, npulse);

        // Reset in the middle of GATE aborts the run.
        @(negedge clk);
        gate_sel = 4'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_busy_before", int'(busy), 1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0, 0);
        check("abort_count", int'(count), 0, 0);
        check("abort_valid", int'(count_valid), 0, 0);
        rst_n = 1'b1;
        count_pulses(1200, npulse);
        check("abort_no_valid", npulse, 0, 0);
`else
        // Continuous mode: one start, then a result every G+5 edges with busy held high.
        begin
            int first_cnt;
            int gap;
            run_meas(0, 6, cyc, cnt, ovf, be, bend, va);
            check("cont_latency", cyc, 70, 70);
            check("cont_count0", cnt, 3, 4);
            check("cont_busy", bend, 1, 1);
            first_cnt = cnt;
            gap = 1;
            for (int p = 1; p < 10; p++) begin
                if (p == 4) start = 1'b1;
                while (!count_valid && gap < 500) begin
                    @(negedge clk);
                    if (!busy) check("cont_busy_hold", int'(busy), 1, 1);
                    gap++;
                end
                start = 1'b0;
                check($sformatf("cont_gap%0d", p), gap, 69, 69);
                check($sformatf("cont_count%0d", p), int'(count), first_cnt - 1, first_cnt + 1);
                @(negedge clk);
                gap = 1;
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
